ioctl_sdram_loader: RTL and testbench

- Upstream stage that takes the HPS byte-wide download stream (ioctl_*) and turns it into 16-bit SDRAM write requests for the memory controller inside the system top.
- Packs byte pairs into little-endian words, buffers them in a small word FIFO, and issues req/ack writes.
- Drives ioctl_wait back to hps_io for flow control and pulses load_done when every byte of a download has been written.

---
 rtl/ioctl_sdram_loader.sv | 186 ++++++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_loader.sv
// Byte-stream to 16-bit SDRAM write bridge: packs ioctl bytes into little-endian
// words, queues them in a small FIFO and issues req/ack writes to the controller.
module ioctl_sdram_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          AW         = 25,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [26:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_be,
  input  logic          mem_ack,
  output logic          load_done,
  output logic [26:0]   byte_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  typedef struct packed {
    logic [25:0] wa;
    logic [15:0] din;
    logic [1:0]  be;
  } word_t;

  word_t         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;

  logic        pend_valid, stg_valid;
  logic [7:0]  pend_lo, stg_hi;
  logic [25:0] pend_wa, stg_wa;
  logic        dl_q, drain;
  logic [0:0]  state;

  logic        accept, dl_rise, dl_fall, push, pop;
  logic        pend_set, pend_clr, stg_set;
  logic [25:0] wa;
  word_t       push_word, head;

  assign wa         = ioctl_addr[26:1];
  assign ioctl_wait = stg_valid | (fifo_count >= (PW+1)'(FIFO_DEPTH-1));
  assign accept     = ioctl_wr & ioctl_download & ~ioctl_wait;
  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = dl_q & ~ioctl_download;
  assign pop        = (state == S_REQ) & mem_ack;
  assign head       = fifo_mem[rd_ptr];

  // Packer: staged byte has priority, then the incoming byte, then the
  // end-of-download flush of a lone even byte. Only one push per cycle.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    stg_set   = 1'b0;
    if (stg_valid) begin
      push      = 1'b1;
      push_word = '{wa: stg_wa, din: {stg_hi, 8'h00}, be: 2'b10};
    end else if (accept) begin
      if (!ioctl_addr[0]) begin
        pend_set = 1'b1;
        if (pend_valid) begin
          push      = 1'b1;
          push_word = '{wa: pend_wa, din: {8'h00, pend_lo}, be: 2'b01};
        end
      end else if (pend_valid && pend_wa == wa) begin
        push      = 1'b1;
        pend_clr  = 1'b1;
        push_word = '{wa: wa, din: {ioctl_dout, pend_lo}, be: 2'b11};
      end else if (pend_valid) begin
        push      = 1'b1;
        pend_clr  = 1'b1;
        stg_set   = 1'b1;
        push_word = '{wa: pend_wa, din: {8'h00, pend_lo}, be: 2'b01};
      end else begin
        push      = 1'b1;
        push_word = '{wa: wa, din: {ioctl_dout, 8'h00}, be: 2'b10};
      end
    end else if (!ioctl_download && pend_valid) begin
      push      = 1'b1;
      pend_clr  = 1'b1;
      push_word = '{wa: pend_wa, din: {8'h00, pend_lo}, be: 2'b01};
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_lo    <= '0;
      pend_wa    <= '0;
      stg_valid  <= 1'b0;
      stg_hi     <= '0;
      stg_wa     <= '0;
    end else begin
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_lo    <= ioctl_dout;
        pend_wa    <= wa;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      stg_valid <= stg_set;
      if (stg_set) begin
        stg_hi <= ioctl_dout;
        stg_wa <= wa;
      end
    end
  end

  // Storage is not reset; clearing the pointers discards any queued words.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_be   <= '0;
    end else begin
      case (state)
        S_IDLE: if (fifo_count != '0) begin
          mem_req  <= 1'b1;
          mem_addr <= AW'(BASE_ADDR) + AW'(head.wa);
          mem_din  <= head.din;
          mem_be   <= head.be;
          state    <= S_REQ;
        end
        S_REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q       <= 1'b0;
      drain      <= 1'b0;
      load_done  <= 1'b0;
      byte_count <= '0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;
      // A restart before drain finishes cancels the pulse; queued words still go out.
      if (dl_rise) begin
        drain <= 1'b0;
      end else if (dl_fall) begin
        drain <= 1'b1;
      end else if (drain && fifo_count == '0 && !pend_valid && !stg_valid && state == S_IDLE) begin
        drain     <= 1'b0;
        load_done <= 1'b1;
      end
      if (dl_rise)     byte_count <= accept ? 27'd1 : 27'd0;
      else if (accept) byte_count <= byte_count + 27'd1;
    end
  end
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: packing, flush, back-pressure, reset, address wrap.
module tb_ioctl_sdram_loader;
  localparam int AW = 25;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [1:0]    be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [26:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait, mem_req, mem_ack, load_done;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_be;
  logic [26:0]   byte_count;

  logic          ioctl_wait2, mem_req2, mem_ack2, load_done2;
  logic [AW-1:0] mem_addr2;
  logic [15:0]   mem_din2;
  logic [1:0]    mem_be2;
  logic [26:0]   byte_count2;

  int  checks = 0;
  int  passes = 0;
  int  ld_cnt = 0;
  int  ld_at  = -1;
  int  ack_dly = 2;
  bit  ack_hold = 1'b0;
  wr_t wq[$];
  wr_t wq2[$];

  always #5 clk = ~clk;

  ioctl_sdram_loader #(.FIFO_DEPTH(4), .AW(AW), .BASE_ADDR(0)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_ack(mem_ack), .load_done(load_done), .byte_count(byte_count));

  ioctl_sdram_loader #(.FIFO_DEPTH(4), .AW(AW), .BASE_ADDR(32'h01FF_FFFF)) dut_wrap (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_be(mem_be2),
    .mem_ack(mem_ack2), .load_done(load_done2), .byte_count(byte_count2));

  assign mem_ack2 = mem_req2;

  // Controller model: acks ack_dly cycles after seeing req, logs each accepted write.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (load_done) begin ld_cnt++; ld_at = wq.size(); end
      if (mem_req2) wq2.push_back('{a: mem_addr2, d: mem_din2, be: mem_be2});
      if (mem_ack || ack_hold || !mem_req) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= ack_dly) begin
        mem_ack = 1'b1;
        wq.push_back('{a: mem_addr, d: mem_din, be: mem_be});
      end else begin
        wcnt++;
      end
    end
  end

  function automatic wr_t msk(input wr_t w);
    w.d = w.d & {{8{w.be[1]}}, {8{w.be[0]}}};
    return w;
  endfunction

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    int t;
    t = 0;
    while (ioctl_wait && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      checks++;
      $display("FAIL send_byte timeout addr=%0d ioctl_wait stuck at %b, required 0", a, ioctl_wait);
    end
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic drain_wait();
    int t;
    t = 0;
    while (ld_cnt == 0 && t < 500) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
  endtask

  task automatic start_dl();
    wq.delete(); wq2.delete(); ld_cnt = 0; ld_at = -1;
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", mem_req); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL reset_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (load_done !== 1'b0) $display("FAIL reset_done got %b exp 0", load_done); else passes++;
    checks++; if (byte_count !== 27'd0) $display("FAIL reset_bc got %0d exp 0", byte_count); else passes++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_seq4();
    wr_t exp[2];
    wr_t got;
    exp[0] = '{a: 25'd0, d: 16'hBBAA, be: 2'b11};
    exp[1] = '{a: 25'd1, d: 16'hDDCC, be: 2'b11};
    ack_dly = 2;
    start_dl();
    send_byte(27'd0, 8'hAA); send_byte(27'd1, 8'hBB);
    send_byte(27'd2, 8'hCC); send_byte(27'd3, 8'hDD);
    ioctl_download = 1'b0;
    drain_wait();
    checks++; if (wq.size() != 2) $display("FAIL seq4_count got %0d exp 2", wq.size()); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = '0;
      if (i < wq.size()) got = msk(wq[i]);
      checks++;
      if (got !== exp[i]) $display("FAIL seq4_write%0d got %h exp %h", i, got, exp[i]); else passes++;
    end
    checks++; if (ld_cnt != 1) $display("FAIL seq4_done_cnt got %0d exp 1", ld_cnt); else passes++;
    checks++; if (ld_at != 2) $display("FAIL seq4_done_after got %0d writes exp 2", ld_at); else passes++;
    checks++; if (byte_count !== 27'd4) $display("FAIL seq4_bc got %0d exp 4", byte_count); else passes++;
  endtask

  task automatic test_odd3();
    wr_t exp[2];
    wr_t got;
    exp[0] = '{a: 25'd0, d: 16'h2211, be: 2'b11};
    exp[1] = '{a: 25'd1, d: 16'h0033, be: 2'b01};
    start_dl();
    send_byte(27'd0, 8'h11); send_byte(27'd1, 8'h22); send_byte(27'd2, 8'h33);
    ioctl_download = 1'b0;
    drain_wait();
    checks++; if (wq.size() != 2) $display("FAIL odd3_count got %0d exp 2", wq.size()); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = '0;
      if (i < wq.size()) got = msk(wq[i]);
      checks++;
      if (got !== exp[i]) $display("FAIL odd3_write%0d got %h exp %h", i, got, exp[i]); else passes++;
    end
    checks++; if (ld_cnt != 1 || ld_at != 2) $display("FAIL odd3_done got cnt=%0d at=%0d exp cnt=1 at=2", ld_cnt, ld_at); else passes++;
    checks++; if (byte_count !== 27'd3) $display("FAIL odd3_bc got %0d exp 3", byte_count); else passes++;
  endtask

  task automatic test_backpressure();
    wr_t got, exp;
    ack_hold = 1'b1;
    ack_dly = 0;
    start_dl();
    fork
      begin
        for (int i = 0; i < 10; i++) send_byte(27'(i), 8'(8'h10 + i));
      end
      begin
        repeat (40) @(negedge clk);
        checks++; if (ioctl_wait !== 1'b1) $display("FAIL bp_wait got %b exp 1", ioctl_wait); else passes++;
        checks++; if (byte_count !== 27'd6) $display("FAIL bp_bc_stalled got %0d exp 6", byte_count); else passes++;
        checks++; if (mem_req !== 1'b1 || wq.size() != 0) $display("FAIL bp_req_held got req=%b writes=%0d exp req=1 writes=0", mem_req, wq.size()); else passes++;
        ack_hold = 1'b0;
      end
    join
    ioctl_download = 1'b0;
    drain_wait();
    checks++; if (wq.size() != 5) $display("FAIL bp_count got %0d exp 5", wq.size()); else passes++;
    for (int i = 0; i < 5; i++) begin
      got = '0;
      if (i < wq.size()) got = msk(wq[i]);
      exp = '{a: 25'(i), d: {8'(8'h11 + 2*i), 8'(8'h10 + 2*i)}, be: 2'b11};
      checks++;
      if (got !== exp) $display("FAIL bp_write%0d got %h exp %h", i, got, exp); else passes++;
    end
    checks++; if (byte_count !== 27'd10) $display("FAIL bp_bc got %0d exp 10", byte_count); else passes++;
    checks++; if (ld_cnt != 1) $display("FAIL bp_done got %0d exp 1", ld_cnt); else passes++;
    ack_dly = 2;
  endtask

  task automatic test_nonseq();
    wr_t exp[2];
    wr_t got;
    exp[0] = '{a: 25'd2, d: 16'h005A, be: 2'b01};
    exp[1] = '{a: 25'd4, d: 16'h7700, be: 2'b10};
    start_dl();
    send_byte(27'd4, 8'h5A);
    send_byte(27'd9, 8'h77);
    checks++; if (ioctl_wait !== 1'b1) $display("FAIL nonseq_stage_wait got %b exp 1", ioctl_wait); else passes++;
    @(negedge clk);
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL nonseq_after_wait got %b exp 0", ioctl_wait); else passes++;
    ioctl_download = 1'b0;
    drain_wait();
    checks++; if (wq.size() != 2) $display("FAIL nonseq_count got %0d exp 2", wq.size()); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = '0;
      if (i < wq.size()) got = msk(wq[i]);
      checks++;
      if (got !== exp[i]) $display("FAIL nonseq_write%0d got %h exp %h", i, got, exp[i]); else passes++;
    end
    checks++; if (byte_count !== 27'd2 || ld_cnt != 1) $display("FAIL nonseq_end got bc=%0d done=%0d exp bc=2 done=1", byte_count, ld_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    ack_hold = 1'b1;
    start_dl();
    for (int i = 0; i < 6; i++) send_byte(27'(i), 8'(8'h40 + i));
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || ioctl_wait !== 1'b1) $display("FAIL rstmid_pre got req=%b wait=%b exp 1/1", mem_req, ioctl_wait); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req got %b exp 0", mem_req); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL rstmid_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (load_done !== 1'b0 || byte_count !== 27'd0) $display("FAIL rstmid_state got done=%b bc=%0d exp 0/0", load_done, byte_count); else passes++;
    ioctl_download = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    wq.delete(); ld_cnt = 0;
    ack_hold = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (wq.size() != 0 || mem_req !== 1'b0) $display("FAIL rstmid_after got writes=%0d req=%b exp 0/0", wq.size(), mem_req); else passes++;
    checks++; if (ld_cnt != 0) $display("FAIL rstmid_done got %0d exp 0", ld_cnt); else passes++;
  endtask

  task automatic test_wrap();
    wr_t got, got2, exp, exp2;
    exp  = '{a: 25'd1, d: 16'h1234, be: 2'b11};
    exp2 = '{a: 25'd0, d: 16'h1234, be: 2'b11};
    start_dl();
    send_byte(27'd2, 8'h34); send_byte(27'd3, 8'h12);
    ioctl_download = 1'b0;
    drain_wait();
    got = '0; got2 = '0;
    if (wq.size() > 0)  got  = msk(wq[0]);
    if (wq2.size() > 0) got2 = msk(wq2[0]);
    checks++; if (got2 !== exp2 || wq2.size() != 1) $display("FAIL wrap_addr got %h (n=%0d) exp %h", got2, wq2.size(), exp2); else passes++;
    checks++; if (got !== exp) $display("FAIL wrap_base0 got %h exp %h", got, exp); else passes++;
  endtask

  initial begin
    test_reset();
    test_seq4();
    test_odd3();
    test_backpressure();
    test_nonseq();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
